sha256_stream_core: RTL and testbench

Next-generation SHA-256 compression engine. It takes a stream of pre-padded 512-bit blocks over a valid/ready handshake and chains multi-block messages through the intermediate hash. An optional double-hash mode (SHA-256d, used by the mining datapath) re-hashes the first digest internally. Throughput is set by a rounds-per-cycle parameter, and the result is presented on a back-pressured output port.

---
 rtl/sha256_stream_core.sv | 210 +++++++++++++++++++++
 tb/tb_sha256_stream_core.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_stream_core.sv
// SHA-256 block compression engine with multi-block chaining,
// optional SHA-256d re-hash and configurable rounds per cycle.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit DOUBLE_HASH_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_double,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ROUND = 3'd1;
  localparam logic [2:0] S_FINAL = 3'd2;
  localparam logic [2:0] S_DBL   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [5:0] RSTEP = 6'(ROUNDS_PER_CYCLE);
  localparam logic [5:0] LAST_RND = 6'(64 - ROUNDS_PER_CYCLE);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(
    input logic [31:0] x,
    input int n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  // Working state packed as {a,b,c,d,e,f,g,h}, a in the top word.
  function automatic logic [255:0] rnd_step(
    input logic [255:0] s,
    input logic [31:0]  k,
    input logic [31:0]  wt
  );
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + bsig1(e) + ((e & f) ^ (~e & g)) + k + wt;
    t2 = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  logic [2:0]   state;
  logic [5:0]   rnd;
  logic [255:0] hh;
  logic [255:0] abcd;
  logic [31:0]  w [16];
  logic         last_q;
  logic         dbl_q;
  logic         rehash;

  logic [31:0]  nxt_w [16];
  logic [255:0] nxt_abcd;
  logic [255:0] h_sum;

  assign in_ready = (state == S_IDLE) && !reset;

  // w[i] holds W[rnd+i]; extend by R words and slide by R.
  always_comb begin : sched
    logic [31:0] e [16+ROUNDS_PER_CYCLE];
    for (int j = 0; j < 16; j++) e[j] = w[j];
    for (int j = 16; j < 16 + ROUNDS_PER_CYCLE; j++) begin
      e[j] = ssig1(e[j-2]) + e[j-7] + ssig0(e[j-15]) + e[j-16];
    end
    for (int j = 0; j < 16; j++) nxt_w[j] = e[j+ROUNDS_PER_CYCLE];
  end

  always_comb begin : rounds
    logic [255:0] cur;
    cur = abcd;
    for (int i = 0; i < ROUNDS_PER_CYCLE; i++) begin
      cur = rnd_step(cur, K[rnd + 6'(i)], w[i]);
    end
    nxt_abcd = cur;
  end

  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i*32 +: 32] = hh[i*32 +: 32] + abcd[i*32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      rnd        <= '0;
      hh         <= IV;
      abcd       <= IV;
      last_q     <= 1'b0;
      dbl_q      <= 1'b0;
      rehash     <= 1'b0;
      out_valid  <= 1'b0;
      out_digest <= '0;
      for (int j = 0; j < 16; j++) w[j] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int j = 0; j < 16; j++) begin
              w[j] <= in_block[511-32*j -: 32];
            end
            last_q <= in_last;
            dbl_q  <= in_double & DOUBLE_HASH_EN;
            if (in_first) begin
              hh   <= IV;
              abcd <= IV;
            end else begin
              abcd <= hh;
            end
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          abcd <= nxt_abcd;
          w    <= nxt_w;
          if (rnd == LAST_RND) begin
            rnd   <= '0;
            state <= S_FINAL;
          end else begin
            rnd <= rnd + RSTEP;
          end
        end
        S_FINAL: begin
          hh <= h_sum;
          if (!last_q) begin
            state <= S_IDLE;
          end else if (dbl_q && !rehash) begin
            state <= S_DBL;
          end else begin
            out_valid  <= 1'b1;
            out_digest <= h_sum;
            state      <= S_DONE;
          end
        end
        S_DBL: begin
          // Second pass hashes the 32-byte digest, pre-padded.
          for (int j = 0; j < 8; j++) w[j] <= hh[255-32*j -: 32];
          w[8] <= 32'h80000000;
          for (int j = 9; j < 15; j++) w[j] <= '0;
          w[15]  <= 32'h00000100;
          hh     <= IV;
          abcd   <= IV;
          rehash <= 1'b1;
          state  <= S_ROUND;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            rehash    <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Bench for sha256_stream_core: four instances (R=1,2,4,8) driven
// in parallel and checked against a plain-arithmetic SHA-256 model.
module tb_sha256_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [3:0]   vld, first, last, dbl;
  logic         out_ready;
  logic [511:0] blk [4];
  wire  [3:0]   rdy, ov;
  wire  [255:0] dig [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_stream_core #(
      .ROUNDS_PER_CYCLE(1 << g),
      .DOUBLE_HASH_EN(1'b1)
    ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(vld[g]),
      .in_ready(rdy[g]),
      .in_block(blk[g]),
      .in_first(first[g]),
      .in_last(last[g]),
      .in_double(dbl[g]),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .out_digest(dig[g])
    );
  end

  int checks = 0;
  int fails = 0;

  localparam logic [255:0] IV_TB = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC =
    {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] TWO_A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] TWO_B = {{15{32'h0}}, 32'h000001c0};

  localparam logic [255:0] D_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC2 =
    256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] D_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  // Current message: blocks with their first/last flags.
  logic [511:0] m_blk [4];
  logic         m_first [4];
  logic         m_last [4];
  int           m_n;
  logic         m_dbl;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(
    input logic [255:0] hin,
    input logic [511:0] b
  );
    logic [31:0] ws [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) ws[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      ws[t] = (ror(ws[t-2], 17) ^ ror(ws[t-2], 19) ^ (ws[t-2] >> 10))
            + ws[t-7]
            + (ror(ws[t-15], 7) ^ ror(ws[t-15], 18) ^ (ws[t-15] >> 3))
            + ws[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + ws[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] model_msg();
    logic [255:0] h;
    logic [511:0] p;
    h = IV_TB;
    for (int b = 0; b < m_n; b++) begin
      if (m_first[b]) h = IV_TB;
      h = compress(h, m_blk[b]);
    end
    if (m_dbl) begin
      p = '0;
      p[511:256] = h;
      p[255] = 1'b1;
      p[63:0] = 64'd256;
      h = compress(IV_TB, p);
    end
    return h;
  endfunction

  task automatic load(input int k, input int i);
    vld[k]   = 1'b1;
    blk[k]   = m_blk[i];
    first[k] = m_first[i];
    last[k]  = m_last[i];
    dbl[k]   = m_dbl & m_last[i];
  endtask

  // Feeds the current message to all four instances independently
  // and checks digest, latency, accept spacing and pulse width.
  task automatic run(input string name, input logic [255:0] exp);
    int idx [4];
    int acc [4][4];
    bit pend [4];
    int oc [4];
    int hi [4];
    logic [255:0] got [4];
    int cyc, done_at, n, lat, elat;
    bit all;
    for (int k = 0; k < 4; k++) begin
      idx[k] = 0; pend[k] = 0; oc[k] = -1; hi[k] = 0;
      load(k, 0);
    end
    cyc = 0;
    done_at = -1;
    while (cyc < 400 && !(done_at >= 0 && cyc > done_at + 3)) begin
      for (int k = 0; k < 4; k++) begin
        if (pend[k]) begin
          pend[k] = 0;
          idx[k]++;
          if (idx[k] < m_n) load(k, idx[k]);
          else vld[k] = 1'b0;
        end
        if (ov[k]) begin
          hi[k]++;
          if (oc[k] < 0) begin
            oc[k] = cyc;
            got[k] = dig[k];
          end
        end
        if (vld[k] && rdy[k]) begin
          pend[k] = 1;
          acc[k][idx[k]] = cyc;
        end
      end
      all = 1;
      for (int k = 0; k < 4; k++) if (oc[k] < 0) all = 0;
      if (done_at < 0 && all) done_at = cyc;
      @(negedge clk);
      cyc++;
    end
    vld = '0;
    for (int k = 0; k < 4; k++) begin
      n = 64 >> k;
      checks++;
      if (oc[k] < 0) begin
        fails++;
        $display("FAIL %s R%0d timeout: no out_valid within %0d cycles",
                 name, 1 << k, cyc);
        continue;
      end
      checks++;
      if (got[k] !== exp) begin
        fails++;
        $display("FAIL %s R%0d digest got %h exp %h",
                 name, 1 << k, got[k], exp);
      end
      lat = oc[k] - acc[k][m_n-1];
      elat = m_dbl ? 2 * n + 4 : n + 2;
      checks++;
      if (lat !== elat) begin
        fails++;
        $display("FAIL %s R%0d latency got %0d exp %0d",
                 name, 1 << k, lat, elat);
      end
      checks++;
      if (hi[k] !== 1) begin
        fails++;
        $display("FAIL %s R%0d out_valid width got %0d exp 1",
                 name, 1 << k, hi[k]);
      end
      for (int b = 0; b + 1 < m_n; b++) begin
        checks++;
        if (acc[k][b+1] - acc[k][b] !== n + 2) begin
          fails++;
          $display("FAIL %s R%0d block%0d gap got %0d exp %0d",
                   name, 1 << k, b, acc[k][b+1] - acc[k][b], n + 2);
        end
      end
    end
  endtask

  task automatic set1(input logic [511:0] b, input logic f,
                      input logic d);
    m_n = 1;
    m_blk[0] = b;
    m_first[0] = f;
    m_last[0] = 1'b1;
    m_dbl = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rdy !== 4'h0 || ov !== 4'h0) begin
      fails++;
      $display("FAIL reset_ctrl got rdy=%b ov=%b exp 0000 0000", rdy, ov);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dig[k] !== '0) begin
        fails++;
        $display("FAIL reset_digest R%0d got %h exp 0", 1 << k, dig[k]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 4'hf) begin
      fails++;
      $display("FAIL reset_idle rdy got %b exp 1111", rdy);
    end
    set1(ABC, 1'b0, 1'b0);
    run("first0_after_reset", D_ABC);
  endtask

  task automatic test_known();
    set1(ABC, 1'b1, 1'b0);
    run("abc", D_ABC);
    set1(ABC, 1'b1, 1'b1);
    run("abc_double", D_ABC2);
    m_n = 2;
    m_blk[0] = TWO_A; m_first[0] = 1'b1; m_last[0] = 1'b0;
    m_blk[1] = TWO_B; m_first[1] = 1'b0; m_last[1] = 1'b1;
    m_dbl = 1'b0;
    run("two_block", D_TWO);
  endtask

  task automatic test_first_restart();
    m_n = 2;
    for (int j = 0; j < 16; j++) m_blk[0][511-32*j -: 32] = $urandom();
    m_first[0] = 1'b1; m_last[0] = 1'b0;
    m_blk[1] = ABC; m_first[1] = 1'b1; m_last[1] = 1'b1;
    m_dbl = 1'b0;
    run("first_restart", D_ABC);
  endtask

  task automatic test_random();
    string nm;
    for (int it = 0; it < 6; it++) begin
      m_n = $urandom_range(1, 3);
      for (int b = 0; b < m_n; b++) begin
        for (int j = 0; j < 16; j++) m_blk[b][511-32*j -: 32] = $urandom();
        m_first[b] = (b == 0);
        m_last[b] = (b == m_n - 1);
      end
      m_dbl = 1'($urandom_range(0, 1));
      nm = $sformatf("random%0d", it);
      run(nm, model_msg());
    end
  endtask

  task automatic test_backpressure();
    int t;
    out_ready = 1'b0;
    set1(EMPTY, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) load(k, 0);
    @(negedge clk);
    vld = '0;
    t = 0;
    while (ov !== 4'hf && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (ov !== 4'hf) begin
      fails++;
      $display("FAIL bp_timeout ov got %b exp 1111", ov);
    end
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (ov !== 4'hf || rdy !== 4'h0) begin
        fails++;
        $display("FAIL bp_hold c%0d got ov=%b rdy=%b exp 1111 0000",
                 c, ov, rdy);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dig[k] !== D_EMPTY) begin
          fails++;
          $display("FAIL bp_digest R%0d c%0d got %h exp %h",
                   1 << k, c, dig[k], D_EMPTY);
        end
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ov !== 4'h0 || rdy !== 4'hf) begin
      fails++;
      $display("FAIL bp_release got ov=%b rdy=%b exp 0000 1111", ov, rdy);
    end
  endtask

  task automatic test_reset_midround();
    set1(ABC, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) load(k, 0);
    @(negedge clk);
    vld = '0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (rdy !== 4'h0 || ov !== 4'h0) begin
      fails++;
      $display("FAIL midreset_during got rdy=%b ov=%b exp 0000 0000",
               rdy, ov);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (rdy !== 4'hf || ov !== 4'h0) begin
      fails++;
      $display("FAIL midreset_after got rdy=%b ov=%b exp 1111 0000",
               rdy, ov);
    end
    set1(ABC, 1'b0, 1'b0);
    run("abc_after_reset", D_ABC);
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    vld = '0;
    first = '0;
    last = '0;
    dbl = '0;
    for (int k = 0; k < 4; k++) blk[k] = '0;
    @(negedge clk);
    test_reset();
    test_known();
    test_first_restart();
    test_random();
    test_backpressure();
    test_reset_midround();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
